fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
- Controller for a time-multiplexed FIR: one shared multiply-accumulate unit replaces the fully pipelined tap chain.
- Owns the sample delay-line memory: a circular buffer written by this block.
- Sequences the sample-buffer and coefficient-ROM read addresses and drives the MAC clear/enable strobes.
- Signals when the accumulator holds a finished output; sits between the audio sample source and the buffer/ROM/MAC datapath.

Parameters:
- DATA_IN_WIDTH, 16, sample width.
- TAP_COUNT, 107, number of taps = buffer depth = coefficient count; must be at least 2.
- ADDR_WIDTH, 7, buffer/ROM address width; must be at least clog2(TAP_COUNT).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- data_in  in  DATA_IN_WIDTH  signed sample.
- buf_we  out  1  sample-buffer write enable.
- buf_waddr  out  ADDR_WIDTH  buffer write address.
- buf_wdata  out  DATA_IN_WIDTH  buffer write data.
- buf_raddr  out  ADDR_WIDTH  buffer read address (1-cycle read latency).
- coef_raddr  out  ADDR_WIDTH  coefficient ROM read address (1-cycle read latency).
- mac_en  out  1  MAC consumes the current buffer/ROM read data this cycle.
- mac_clr  out  1  with mac_en: load the product instead of adding it.
- out_valid  out  1  one-cycle pulse: accumulator holds a complete output.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: CLEAR, IDLE, RUN, FLUSH, DONE.
- While reset_n=0:
  - state=CLEAR, clear index=0, wr_ptr=0.
  - buf_we=0, mac_en=0, mac_clr=0, out_valid=0, in_ready=0, busy=1.
  - All address outputs = 0.
- CLEAR:
  - Starts at the first clock after reset release.
  - buf_we=1, buf_waddr = 0..TAP_COUNT-1 on consecutive cycles, buf_wdata=0.
  - in_ready=0.
  - After address TAP_COUNT-1 is written, moves to IDLE.
- IDLE:
  - in_ready=1, busy=0.
  - Accept occurs on in_valid & in_ready; this is cycle 0.
  - In the accept cycle, buf_we=1, buf_waddr=wr_ptr and buf_wdata=data_in, all combinational from the handshake.
  - head is latched to wr_ptr.
  - wr_ptr increments, wrapping from TAP_COUNT-1 to 0.
  - Next state is RUN with k=0.
- RUN, cycles 1..TAP_COUNT:
  - buf_raddr = (head - k) mod TAP_COUNT, generated as a decrementing pointer that wraps from 0 to TAP_COUNT-1.
  - coef_raddr = k, for k = 0..TAP_COUNT-1.
  - in_ready=0.
  - After k=TAP_COUNT-1, moves to FLUSH.
- mac_en is the one-cycle-delayed "read issued" flag: it is high for cycles 2..TAP_COUNT+1.
- mac_clr is high only together with the first mac_en (cycle 2).
- FLUSH, cycle TAP_COUNT+1:
  - No new read is issued.
  - mac_en is high for the last read.
- DONE, cycle TAP_COUNT+2:
  - out_valid=1 for exactly one cycle.
  - Moves to IDLE.
- Throughput: one sample every TAP_COUNT+3 cycles, i.e. 110 cycles at the default TAP_COUNT.
- Backpressure:
  - in_valid while not in IDLE is ignored; data_in is not sampled.
  - The source holds the sample until in_ready is high.
- Wrap: the write and read pointers never leave 0..TAP_COUNT-1; addresses at or above TAP_COUNT are never driven.
- Reset mid-operation:
  - All strobes drop immediately (asynchronous), and any partial result is discarded (no out_valid).
  - The CLEAR sequence fully repeats and wr_ptr restarts at 0.
- All state, pointers, mac_en, mac_clr and out_valid are registered.
- in_ready, busy and the buffer write port are decoded from state and the handshake.

Test Plan:
- Release reset → buf_we high for 107 consecutive cycles with buf_waddr 0..106 and buf_wdata 0, in_ready=0; in_ready=1 on the following cycle.
- Accept 16'sh7FFF at wr_ptr=0 →
  - buf_raddr = 0,106,105,…,1 and coef_raddr = 0..106 on cycles 1..107.
  - mac_en on cycles 2..108, mac_clr only on cycle 2.
  - out_valid pulse only on cycle 109.
- Wrap: after 112 accepts, the 113th is written at buf_waddr 5; its reads are 5,4,…,0,106,…,6.
- in_valid held high with data_in changing every cycle →
  - Exactly one accept every 110 cycles.
  - Only the values present in the accept cycles appear on buf_wdata.
  - in_ready=0 and busy=1 between accepts.
- Pull reset_n low at RUN k=50 →
  - mac_en, out_valid and buf_we go to 0 without waiting for a clock edge.
  - After release, the full 107-cycle CLEAR repeats and the first accept writes address 0.
- Behavioural buffer/ROM/MAC models with the 107-tap coefficient set and a sine input → each out_valid result equals the golden convolution of the last 107 samples, exactly (bit-true).

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Address and strobe sequencer for a time-multiplexed FIR built around one shared MAC.
// Owns the circular sample delay line: clears it after reset, then writes one sample per output.
module fir_mac_sequencer #(
    parameter int DATA_IN_WIDTH = 16,
    parameter int TAP_COUNT     = 107,
    parameter int ADDR_WIDTH    = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_IN_WIDTH-1:0] data_in,
    output logic                     buf_we,
    output logic [ADDR_WIDTH-1:0]    buf_waddr,
    output logic [DATA_IN_WIDTH-1:0] buf_wdata,
    output logic [ADDR_WIDTH-1:0]    buf_raddr,
    output logic [ADDR_WIDTH-1:0]    coef_raddr,
    output logic                     mac_en,
    output logic                     mac_clr,
    output logic                     out_valid,
    output logic                     busy
);

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TAP_COUNT - 1);

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? ZERO_ADDR : p + ONE_ADDR;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] ptr_dec(input logic [ADDR_WIDTH-1:0] p);
        return (p == ZERO_ADDR) ? LAST_ADDR : p - ONE_ADDR;
    endfunction

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   clr_idx_r;
    logic [ADDR_WIDTH-1:0]   wr_ptr_r;
    logic [ADDR_WIDTH-1:0]   rd_ptr_r;
    logic [ADDR_WIDTH-1:0]   k_r;
    logic                    mac_en_r;
    logic                    mac_clr_r;
    logic                    out_valid_r;
    logic                    accept_s;
    logic                    in_ready_s;
    logic                    busy_s;
    logic                    buf_we_s;
    logic [ADDR_WIDTH-1:0]   buf_waddr_s;
    logic [DATA_IN_WIDTH-1:0] buf_wdata_s;

    // Handshake and write-port decode; the clear write is gated by reset_n so it drops asynchronously.
    always_comb begin
        accept_s    = 1'b0;
        in_ready_s  = 1'b0;
        busy_s      = 1'b1;
        buf_we_s    = 1'b0;
        buf_waddr_s = wr_ptr_r;
        buf_wdata_s = {DATA_IN_WIDTH{1'b0}};
        case (state_r)
            CLEAR: begin
                buf_we_s    = reset_n;
                buf_waddr_s = clr_idx_r;
            end
            IDLE: begin
                in_ready_s  = 1'b1;
                busy_s      = 1'b0;
                accept_s    = in_valid;
                buf_we_s    = in_valid;
                buf_wdata_s = data_in;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Sequencer state, pointers and the registered MAC/output strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= CLEAR;
            clr_idx_r   <= ZERO_ADDR;
            wr_ptr_r    <= ZERO_ADDR;
            rd_ptr_r    <= ZERO_ADDR;
            k_r         <= ZERO_ADDR;
            mac_en_r    <= 1'b0;
            mac_clr_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            // Read data arrives one cycle after the address, so the strobes trail the read by one cycle.
            mac_en_r    <= (state_r == RUN);
            mac_clr_r   <= (state_r == RUN) && (k_r == ZERO_ADDR);
            out_valid_r <= (state_r == FLUSH);
            case (state_r)
                CLEAR: begin
                    if (clr_idx_r == LAST_ADDR) begin
                        clr_idx_r <= ZERO_ADDR;
                        state_r   <= IDLE;
                    end else begin
                        clr_idx_r <= clr_idx_r + ONE_ADDR;
                    end
                end
                IDLE: begin
                    if (accept_s) begin
                        rd_ptr_r <= wr_ptr_r;
                        k_r      <= ZERO_ADDR;
                        wr_ptr_r <= ptr_inc(wr_ptr_r);
                        state_r  <= RUN;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    if (k_r == LAST_ADDR) begin
                        state_r <= FLUSH;
                    end else begin
                        k_r      <= k_r + ONE_ADDR;
                        rd_ptr_r <= ptr_dec(rd_ptr_r);
                    end
                end
                FLUSH: state_r <= DONE;
                DONE:  state_r <= IDLE;
                default: state_r <= CLEAR;
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign busy       = busy_s;
    assign buf_we     = buf_we_s;
    assign buf_waddr  = buf_waddr_s;
    assign buf_wdata  = buf_wdata_s;
    assign buf_raddr  = rd_ptr_r;
    assign coef_raddr = k_r;
    assign mac_en     = mac_en_r;
    assign mac_clr    = mac_clr_r;
    assign out_valid  = out_valid_r;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with behavioural buffer, ROM and MAC, checked against a golden convolution.
module tb_fir_mac_sequencer;

    localparam int TAPS = 107;

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] data_in;
    logic               buf_we;
    logic [6:0]         buf_waddr;
    logic [15:0]        buf_wdata;
    logic [6:0]         buf_raddr;
    logic [6:0]         coef_raddr;
    logic               mac_en;
    logic               mac_clr;
    logic               out_valid;
    logic               busy;

    int n_vec;
    int n_err;
    int n_acc;

    fir_mac_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .buf_we     (buf_we),
        .buf_waddr  (buf_waddr),
        .buf_wdata  (buf_wdata),
        .buf_raddr  (buf_raddr),
        .coef_raddr (coef_raddr),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input longint observed, input longint expected);
        n_vec++;
        if (observed != expected) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Behavioural datapath: sample RAM, coefficient ROM and accumulator.
    logic signed [15:0] mem [0:TAPS-1];
    logic signed [15:0] rom [0:TAPS-1];
    logic signed [15:0] buf_rdata;
    logic signed [15:0] coef_rdata;
    longint             acc;
    logic signed [15:0] hist [$];

    initial begin
        for (int k = 0; k < TAPS; k++) rom[k] = 16'(((k * 73 + 11) % 601) - 300);
        acc = 0;
    end

    always @(posedge clk) begin
        if (buf_we) mem[buf_waddr] <= buf_wdata;
        buf_rdata  <= mem[buf_raddr];
        coef_rdata <= rom[coef_raddr];
        if (mac_en) acc <= mac_clr ? longint'(buf_rdata) * longint'(coef_rdata)
                                   : acc + longint'(buf_rdata) * longint'(coef_rdata);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
        end else if (in_valid && in_ready) begin
            hist.push_front(data_in);
            if (hist.size() > TAPS) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            longint g;
            g = 0;
            for (int k = 0; k < TAPS; k++)
                if (k < hist.size()) g += longint'(hist[k]) * longint'(rom[k]);
            check_value("conv", acc, g);
        end
    end

    // Called just after reset release following a posedge.
    task automatic check_clear();
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clk);
            check_value("clr_we", buf_we, 1);
            check_value("clr_waddr", buf_waddr, i);
            check_value("clr_wdata", buf_wdata, 0);
            check_value("clr_ready", in_ready, 0);
            check_value("clr_busy", busy, 1);
            check_value("clr_mac_en", mac_en, 0);
            check_value("clr_ov", out_valid, 0);
        end
        @(negedge clk);
        check_value("idle_ready", in_ready, 1);
        check_value("idle_busy", busy, 0);
        check_value("idle_we", buf_we, 0);
    endtask

    // Called at a negedge; returns at the negedge of the out_valid cycle.
    task automatic run_sample(input logic signed [15:0] d);
        int t;
        int head;
        head = n_acc % TAPS;
        t = 0;
        in_valid = 1'b1;
        data_in  = d;
        #1;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_value("accept_ready", in_ready, 1);
        check_value("acc_we", buf_we, 1);
        check_value("acc_waddr", buf_waddr, head);
        check_value("acc_wdata", longint'($signed(buf_wdata)), longint'(d));
        n_acc++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = ~d;
        for (int c = 1; c <= 109; c++) begin
            @(negedge clk);
            if (c <= TAPS) begin
                check_value("raddr", buf_raddr, (head - (c - 1) + TAPS) % TAPS);
                check_value("coef_raddr", coef_raddr, c - 1);
            end
            check_value("mac_en", mac_en, (c >= 2 && c <= 108) ? 1 : 0);
            check_value("mac_clr", mac_clr, (c == 2) ? 1 : 0);
            check_value("out_valid", out_valid, (c == 109) ? 1 : 0);
            check_value("run_ready", in_ready, 0);
            check_value("run_busy", busy, 1);
            check_value("run_we", buf_we, 0);
        end
    endtask

    initial begin
        logic signed [15:0] s;
        logic signed [15:0] cur_d;
        n_vec    = 0;
        n_err    = 0;
        n_acc    = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        data_in  = 16'sh0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_we", buf_we, 0);
        check_value("rst_mac_en", mac_en, 0);
        check_value("rst_mac_clr", mac_clr, 0);
        check_value("rst_ov", out_valid, 0);
        check_value("rst_ready", in_ready, 0);
        check_value("rst_busy", busy, 1);
        check_value("rst_waddr", buf_waddr, 0);
        check_value("rst_raddr", buf_raddr, 0);
        check_value("rst_coef", coef_raddr, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        check_clear();

        // Impulse of full scale, then a sine; the 113th accept lands on address 5.
        run_sample(16'sh7FFF);
        for (int i = 1; i < 113; i++) begin
            s = 16'($rtoi(24000.0 * $sin(2.0 * 3.14159265 * i / 37.0)));
            run_sample(s);
        end

        // Source holds in_valid with data changing each cycle.
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 330; cyc++) begin
            @(posedge clk);
            #1;
            cur_d   = 16'(16'h4000 + cyc * 7);
            data_in = cur_d;
            @(negedge clk);
            check_value("bp_we", buf_we, (cyc % 110 == 0) ? 1 : 0);
            check_value("bp_ready", in_ready, (cyc % 110 == 0) ? 1 : 0);
            check_value("bp_busy", busy, (cyc % 110 == 0) ? 0 : 1);
            if (cyc % 110 == 0) begin
                check_value("bp_wdata", buf_wdata, cur_d);
                check_value("bp_waddr", buf_waddr, n_acc % TAPS);
                n_acc++;
            end
        end
        in_valid = 1'b0;

        // Reset in the middle of RUN at k=50.
        in_valid = 1'b1;
        data_in  = 16'sh1234;
        #1;
        for (int t = 0; t < 300 && !in_ready; t++) @(negedge clk);
        check_value("mid_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        check_value("mid_k", coef_raddr, 50);
        check_value("mid_mac_en", mac_en, 1);
        reset_n = 1'b0;
        #1;
        check_value("arst_mac_en", mac_en, 0);
        check_value("arst_ov", out_valid, 0);
        check_value("arst_we", buf_we, 0);
        check_value("arst_busy", busy, 1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check_clear();
        n_acc = 0;
        run_sample(16'sh0100);
        run_sample(-16'sd2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
